// File: rtl/freqtable_requester.sv
// freqtable_requester: holds one pending frequency-table lookup per channel and
// issues them one at a time, round-robin, as registered one-hot requests toward
// the 16-channel sharer. A positional delay line tells each voice when the
// sharer's output register holds the word it asked for.
module freqtable_requester #(
  parameter int REQ_GAP = 0,  // idle cycles forced between consecutive requests (0..15)
  parameter int RD_LAT  = 2   // request-to-output-register latency of the sharer
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        note_wr,
  input  logic [3:0]  note_ch,
  input  logic [9:0]  note_addr,
  output logic [15:0] req_valid,
  output logic [9:0]  req_addr,
  output logic [15:0] freq_ready,
  output logic [15:0] pending,
  output logic        idle
);

  localparam logic [3:0] GAP_LOAD = 4'(REQ_GAP);

  logic [9:0]  addr_reg [16];
  logic [15:0] pend_reg;
  logic [15:0] pend_next;
  logic [3:0]  rr_ptr_reg;
  logic [3:0]  gap_cnt_reg;
  logic [15:0] req_valid_reg;
  logic [9:0]  req_addr_reg;
  logic        grant;
  logic [3:0]  sel;
  logic [3:0]  idx;
  logic        pipe_busy;

  // Round-robin pick: first pending channel at or after rr_ptr, wrapping 15->0.
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    grant = 1'b0;
    sel   = 4'd0;
    idx   = 4'd0;
    if (gap_cnt_reg == 4'd0) begin
      for (int i = 15; i >= 0; i--) begin
        idx = rr_ptr_reg + 4'(i);
        if (pend_reg[idx]) begin
          grant = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  // Pending flags: a grant clears its channel, but a same-cycle write sets it
  // again so the newer address gets its own request later.
  always_comb begin
    pend_next = pend_reg;
    if (grant) pend_next[sel] = 1'b0;
    if (note_wr) pend_next[note_ch] = 1'b1;
  end

  // Address table; a granted read sees the value from before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) addr_reg[k] <= 10'd0;
    end else if (note_wr) begin
      addr_reg[note_ch] <= note_addr;
    end
  end

  // Arbiter state: pending set, round-robin pointer and inter-request gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg    <= 16'd0;
      rr_ptr_reg  <= 4'd0;
      gap_cnt_reg <= 4'd0;
    end else begin
      pend_reg <= pend_next;
      if (grant) begin
        rr_ptr_reg  <= sel + 4'd1;
        gap_cnt_reg <= GAP_LOAD;
      end else if (gap_cnt_reg != 4'd0) begin
        gap_cnt_reg <= gap_cnt_reg - 4'd1;
      end
    end
  end

  // Request register: one-hot valid for a single cycle, address held between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_reg <= 16'd0;
      req_addr_reg  <= 10'd0;
    end else if (grant) begin
      req_valid_reg <= 16'd1 << sel;
      req_addr_reg  <= addr_reg[sel];
    end else begin
      req_valid_reg <= 16'd0;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign freq_ready = req_valid_reg;
      assign pipe_busy  = 1'b0;
    end else begin : g_pipe
      logic [15:0] pipe_reg [RD_LAT];

      // Delay line mirroring the sharer's latency; cleared on reset so no
      // stale ready pulse escapes for a discarded request.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < RD_LAT; k++) pipe_reg[k] <= 16'd0;
        end else begin
          pipe_reg[0] <= req_valid_reg;
          for (int k = 1; k < RD_LAT; k++) pipe_reg[k] <= pipe_reg[k-1];
        end
      end

      // Any stage occupied means a lookup is still in flight.
      always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < RD_LAT; k++) pipe_busy = pipe_busy | (pipe_reg[k] != 16'd0);
      end

      assign freq_ready = pipe_reg[RD_LAT-1];
    end
  endgenerate

  assign req_valid = req_valid_reg;
  assign req_addr  = req_addr_reg;
  assign pending   = pend_reg;
  assign idle      = (pend_reg == 16'd0) && (req_valid_reg == 16'd0) &&
                     !pipe_busy && (gap_cnt_reg == 4'd0);

endmodule

// File: tb/tb_freqtable_requester.sv
// Bench for freqtable_requester: two instances (REQ_GAP=0 and REQ_GAP=4) share
// one stimulus; each scenario compares the instance it is about.
`timescale 1ns/1ps
module tb_freqtable_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        note_wr;
  logic [3:0]  note_ch;
  logic [9:0]  note_addr;
  logic [15:0] rv0, fr0, pd0, rv4, fr4, pd4;
  logic [9:0]  ra0, ra4;
  logic        id0, id4;
  logic        armed = 1'b0;

  freqtable_requester #(.REQ_GAP(0), .RD_LAT(2)) u0 (
    .clk(clk), .rst(rst), .note_wr(note_wr), .note_ch(note_ch), .note_addr(note_addr),
    .req_valid(rv0), .req_addr(ra0), .freq_ready(fr0), .pending(pd0), .idle(id0)
  );

  freqtable_requester #(.REQ_GAP(4), .RD_LAT(2)) u4 (
    .clk(clk), .rst(rst), .note_wr(note_wr), .note_ch(note_ch), .note_addr(note_addr),
    .req_valid(rv4), .req_addr(ra4), .freq_ready(fr4), .pending(pd4), .idle(id4)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  ch;
    logic [9:0]  addr;
    logic [15:0] rv;
    logic [9:0]  ra;
    logic [15:0] fr;
    logic [15:0] pd;
    logic        idl;
  } vec_t;

  vec_t tbl [0:31];
  int   tlen;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
    end
  endtask

  // At most one request per cycle on either instance.
  always @(negedge clk) begin
    if (armed && !rst) begin
      n_vec++;
      if (!$onehot0(rv0) || !$onehot0(rv4)) begin
        n_err++;
        $display("FAIL onehot at %0t: got rv0=%h rv4=%h want at most one bit", $time, rv0, rv4);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    note_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
  endtask

  task automatic new_tbl(input int n);
    tlen = n;
    for (int i = 0; i < n; i++) tbl[i] = '{1'b0, 4'd0, 10'd0, 16'd0, 10'd0, 16'd0, 16'd0, 1'b1};
  endtask

  task automatic wr_at(input int c, input int ch, input logic [9:0] a);
    tbl[c].wr = 1'b1; tbl[c].ch = 4'(ch); tbl[c].addr = a;
  endtask

  task automatic rq_at(input int c, input logic [15:0] v, input logic [9:0] a);
    tbl[c].rv = v; tbl[c].ra = a;
  endtask

  task automatic fr_at(input int c, input logic [15:0] v);
    tbl[c].fr = v;
  endtask

  task automatic pd_rng(input int a, input int b, input logic [15:0] v);
    for (int i = a; i <= b; i++) tbl[i].pd = v;
  endtask

  task automatic busy_rng(input int a, input int b);
    for (int i = a; i <= b; i++) tbl[i].idl = 1'b0;
  endtask

  // Apply a table from a fresh reset; cycle 0 is the first cycle out of reset.
  task automatic run_tbl(input string name, input bit use4);
    logic [15:0] rv, fr, pd;
    logic [9:0]  ra;
    logic        id;
    do_reset();
    for (int c = 0; c < tlen; c++) begin
      note_wr = tbl[c].wr; note_ch = tbl[c].ch; note_addr = tbl[c].addr;
      @(negedge clk);
      rv = use4 ? rv4 : rv0;
      ra = use4 ? ra4 : ra0;
      fr = use4 ? fr4 : fr0;
      pd = use4 ? pd4 : pd0;
      id = use4 ? id4 : id0;
      chk({name, "/req_valid"}, c, rv, tbl[c].rv);
      if (tbl[c].rv != 16'd0) chk({name, "/req_addr"}, c, 16'(ra), 16'(tbl[c].ra));
      chk({name, "/freq_ready"}, c, fr, tbl[c].fr);
      chk({name, "/pending"}, c, pd, tbl[c].pd);
      chk({name, "/idle"}, c, 16'(id), 16'(tbl[c].idl));
      $display("%s c%0d wr=%0b ch=%0d rv=%h ra=%h fr=%h pd=%h idle=%0b",
               name, c, tbl[c].wr, tbl[c].ch, rv, ra, fr, pd, id);
      @(posedge clk); #1;
    end
    note_wr = 1'b0;
  endtask

  // Expected grant for a channel burst written one per cycle from cycle 0 into
  // the REQ_GAP=4 instance: channel k is requested in cycle 2+5k.
  task automatic chk_burst(input string name, input int c, input int nch, input logic [9:0] base);
    int k;
    logic [15:0] ev;
    logic [9:0]  ea;
    ev = 16'd0; ea = 10'd0;
    if (c >= 2 && (c - 2) % 5 == 0) begin
      k = (c - 2) / 5;
      if (k < nch) begin
        ev = 16'd1 << k;
        ea = base + 10'(k);
      end
    end
    chk({name, "/req_valid"}, c, rv4, ev);
    if (ev != 16'd0) chk({name, "/req_addr"}, c, 16'(ra4), 16'(ea));
    $display("%s c%0d rv=%h ra=%h pd=%h", name, c, rv4, ra4, pd4);
  endtask

  initial begin
    rst = 1'b1; note_wr = 1'b0; note_ch = 4'd0; note_addr = 10'd0;

    // Reset held 3 cycles while writes toggle: nothing may get through.
    for (int k = 0; k < 3; k++) begin
      note_wr = k[0] ? 1'b0 : 1'b1; note_ch = 4'(k + 3); note_addr = 10'(k + 'h50);
      @(negedge clk);
      if (k > 0) begin
        chk("rst/rv", k, rv0 | rv4, 16'd0);
        chk("rst/fr", k, fr0 | fr4, 16'd0);
        chk("rst/pd", k, pd0 | pd4, 16'd0);
        chk("rst/idle", k, 16'({id0, id4}), 16'd3);
        chk("rst/ra", k, 16'(ra0 | ra4), 16'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; note_wr = 1'b0; armed = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("postrst/rv", c, rv0 | rv4, 16'd0);
      chk("postrst/pd", c, pd0 | pd4, 16'd0);
      chk("postrst/idle", c, 16'({id0, id4}), 16'd3);
      $display("postrst c%0d rv0=%h rv4=%h pd0=%h idle=%0b%0b", c, rv0, rv4, pd0, id0, id4);
      @(posedge clk); #1;
    end

    // Single lookup, back-to-back mode.
    new_tbl(17);
    wr_at(10, 5, 10'h045);
    pd_rng(11, 11, 16'h0020);
    rq_at(12, 16'h0020, 10'h045);
    fr_at(14, 16'h0020);
    busy_rng(11, 14);
    run_tbl("single", 1'b0);

    // Round-robin order with a 4-cycle gap.
    new_tbl(19);
    wr_at(1, 2, 10'h0A2); wr_at(2, 1, 10'h0A1); wr_at(3, 7, 10'h0A7);
    pd_rng(2, 2, 16'h0004); pd_rng(3, 3, 16'h0002);
    pd_rng(4, 7, 16'h0082); pd_rng(8, 12, 16'h0002);
    rq_at(3, 16'h0004, 10'h0A2); rq_at(8, 16'h0080, 10'h0A7); rq_at(13, 16'h0002, 10'h0A1);
    fr_at(5, 16'h0004); fr_at(10, 16'h0080); fr_at(15, 16'h0002);
    busy_rng(2, 16);
    run_tbl("rrobin", 1'b1);

    // Overwrite of a pending channel: only the latest address is requested.
    new_tbl(14);
    wr_at(1, 0, 10'h033); wr_at(4, 4, 10'h100); wr_at(5, 4, 10'h200);
    pd_rng(2, 2, 16'h0001); pd_rng(5, 7, 16'h0010);
    rq_at(3, 16'h0001, 10'h033); rq_at(8, 16'h0010, 10'h200);
    fr_at(5, 16'h0001); fr_at(10, 16'h0010);
    busy_rng(2, 11);
    run_tbl("overwrite", 1'b1);

    // Write colliding with its own grant: old address now, new address next.
    new_tbl(9);
    wr_at(1, 6, 10'h011); wr_at(2, 6, 10'h022);
    pd_rng(2, 3, 16'h0040);
    rq_at(3, 16'h0040, 10'h011); rq_at(4, 16'h0040, 10'h022);
    fr_at(5, 16'h0040); fr_at(6, 16'h0040);
    busy_rng(2, 6);
    run_tbl("collision", 1'b0);

    // Reset mid-flight on the gapped instance: all 16 channels written, then
    // reset one cycle after the third grant that follows the write burst.
    do_reset();
    for (int c = 0; c < 28; c++) begin
      note_wr = (c < 16); note_ch = 4'(c); note_addr = 10'h300 + 10'(c);
      @(negedge clk);
      chk_burst("midflight", c, 16, 10'h300);
      @(posedge clk); #1;
    end
    note_wr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst/pd", 0, pd4, 16'd0);
    chk("midrst/idle", 0, 16'(id4), 16'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst/rv", c, rv4 | rv0, 16'd0);
      chk("midrst/fr", c, fr4 | fr0, 16'd0);
      $display("midrst c%0d rv4=%h fr4=%h pd4=%h", c, rv4, fr4, pd4);
      @(posedge clk); #1;
    end
    for (int c = 0; c < 19; c++) begin
      note_wr = (c < 4); note_ch = 4'(c); note_addr = 10'h1C0 + 10'(c);
      @(negedge clk);
      chk_burst("restart", c, 4, 10'h1C0);
      @(posedge clk); #1;
    end
    note_wr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
